mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single word-wide main-memory port between the instruction cache (client 0, read-only)
//  and the data cache (client 1, read and write). Grants whole line bursts of LINE_WIDTH beats, with
//  round-robin between clients. Adds zero latency: the request is forwarded to memory in the cycle it wins.
// PARAMETERS
//  ADDR_WIDTH  16  word-address width, identical on all ports
//  DATA_WIDTH  32  bits per word
//  LINE_WIDTH  4   beats per burst (power of 2); must equal the caches' line width
// PORTS
//  clk          in   1           clock
//  rstn         in   1           synchronous, active-low reset
//  ic_rd_en     in   1           icache read request (held for the whole refill)
//  ic_rd_addr   in   ADDR_WIDTH  icache word address
//  ic_rd_data   out  DATA_WIDTH  read data (= mem_rd_data)
//  ic_rd_valid  out  1           icache beat valid
//  dc_rd_en     in   1           dcache read request
//  dc_wr_en     in   1           dcache write request
//  dc_addr      in   ADDR_WIDTH  dcache word address
//  dc_wr_data   in   DATA_WIDTH  dcache write data
//  dc_wr_sel    in   4           dcache byte enables
//  dc_rd_data   out  DATA_WIDTH  read data (= mem_rd_data)
//  dc_rd_valid  out  1           dcache read beat valid
//  dc_wr_ack    out  1           dcache write beat accepted
//  mem_rd_en    out  1           memory read request
//  mem_wr_en    out  1           memory write request
//  mem_addr     out  ADDR_WIDTH  memory word address
//  mem_wr_data  out  DATA_WIDTH  memory write data
//  mem_wr_sel   out  4           memory byte enables
//  mem_rd_data  in   DATA_WIDTH  memory read data
//  mem_rd_valid in   1           memory read beat valid
//  mem_wr_ack   in   1           memory write beat accepted
//  gnt          out  2           one-hot current owner {dc,ic}; 0 when idle
// BEHAVIOUR
//  - FSM states: IDLE, GNT_IC, GNT_DC. Registers: state, beat counter (clog2(LINE_WIDTH)+1 bits),
//    last_gnt, burst type (RD/WR).
//  - IDLE:
//    - The winner is chosen combinationally. Its enable, address, data and sel are driven to memory in
//      the same cycle, and gnt shows it in that cycle.
//    - The state moves to GNT_x on the next edge, with the counter cleared.
//    - If both clients request, the client not equal to last_gnt wins.
//    - If only one client requests, it wins. last_gnt is updated on every grant.
//  - dcache burst type: dc_wr_en has priority over dc_rd_en (writeback before refill).
//    - The type is latched at grant.
//    - During the burst the opposite-type enable is ignored, and mem_rd_en and mem_wr_en are never both 1.
//  - Granted state:
//    - The owner's signals are muxed to memory.
//    - Each mem_rd_valid (RD) or mem_wr_ack (WR) is one beat. It is routed to the owner's valid/ack and
//      increments the counter.
//    - The beat in the IDLE grant cycle also counts.
//  - Release: return to IDLE on the edge after the LINE_WIDTH-th beat. In the cycle after the final beat
//    (counter == LINE_WIDTH) all mem enables are forced to 0.
//  - Abort: if the owner's latched-type enable is 0 in a granted state, return to IDLE next edge.
//    The counter is discarded and no beat is routed in that cycle.
//  - The non-owner's valid/ack is always 0. rd_data is broadcast to both clients unqualified.
//  - In IDLE with no winner: all mem enables = 0, gnt = 0, and stray mem_rd_valid/mem_wr_ack are ignored.
//  - Reset (rstn = 0 at clk edge):
//    - state = IDLE, counter = 0, last_gnt = dc (so icache wins the first tie), type = RD.
//    - While rstn is low: mem_rd_en = mem_wr_en = 0, all valid/ack = 0, gnt = 0.
//    - Reset mid-burst abandons the burst; no further beats are routed.
// TESTING
//  - ic_rd_en alone, addr 0x0040; memory returns 4 valids on consecutive cycles ->
//    mem_rd_en in the same cycle, ic_rd_valid x4, gnt = 01, IDLE after the 4th beat.
//  - ic_rd_en and dc_rd_en rise together after reset -> ic served first (4 beats),
//    then dc granted in the next IDLE cycle; no dc_rd_valid during the ic burst.
//  - dc_wr_en and dc_rd_en both high, addr 0x1230 -> 4 write beats (mem_wr_en, dc_wr_ack x4),
//    then re-arbitrated read burst; mem_rd_en = 0 throughout the writes.
//  - Memory inserts 3-cycle gaps between valids -> grant held, counter advances only on valid,
//    release only after beat 4.
//  - Stray mem_rd_valid in IDLE -> no client valid. dc drops dc_rd_en after 2 beats -> IDLE next edge,
//    a pending ic request is granted.
//  - rstn low during beat 2 of an ic burst -> gnt = 0 and enables 0 next cycle;
//    after release a fresh ic request restarts at its base address.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin line-burst arbiter sharing one memory port between icache and dcache
module mem_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  ic_rd_en,
    input  logic [ADDR_WIDTH-1:0] ic_rd_addr,
    output logic [DATA_WIDTH-1:0] ic_rd_data,
    output logic                  ic_rd_valid,
    input  logic                  dc_rd_en,
    input  logic                  dc_wr_en,
    input  logic [ADDR_WIDTH-1:0] dc_addr,
    input  logic [DATA_WIDTH-1:0] dc_wr_data,
    input  logic [3:0]            dc_wr_sel,
    output logic [DATA_WIDTH-1:0] dc_rd_data,
    output logic                  dc_rd_valid,
    output logic                  dc_wr_ack,
    output logic                  mem_rd_en,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic [3:0]            mem_wr_sel,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    input  logic                  mem_rd_valid,
    input  logic                  mem_wr_ack,
    output logic [1:0]            gnt
);
    localparam int CW = $clog2(LINE_WIDTH) + 1;
    localparam logic [CW-1:0] LINE = CW'(LINE_WIDTH);

    typedef enum logic [1:0] {IDLE, GNT_IC, GNT_DC} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx, cnt_inc;
    logic          last_dc, last_dc_nx, bt_wr, bt_wr_nx;
    logic          dc_req, own_dc, own_wr, own_en, busy, beat, act;

    assign dc_req = dc_rd_en || dc_wr_en;

    // Owner selection: arbitrate in IDLE (skipped in the cycle right after a full line), else the latched owner
    always_comb begin
        own_dc = 1'b0;
        own_wr = 1'b0;
        own_en = 1'b0;
        busy   = 1'b0;
        case (state)
            GNT_IC: begin
                own_en = ic_rd_en;
                busy   = 1'b1;
            end
            GNT_DC: begin
                own_dc = 1'b1;
                own_wr = bt_wr;
                own_en = bt_wr ? dc_wr_en : dc_rd_en;
                busy   = 1'b1;
            end
            default: if (cnt != LINE) begin
                own_dc = dc_req && !(ic_rd_en && last_dc);
                own_wr = own_dc && dc_wr_en;
                own_en = ic_rd_en || dc_req;
            end
        endcase
    end

    assign beat    = own_en && (own_wr ? mem_wr_ack : mem_rd_valid);
    assign cnt_inc = cnt + CW'(beat);

    // Next state: a dropped enable or a completed line returns to IDLE; the grant cycle latches owner and type
    always_comb begin
        state_nx   = (!own_en || cnt_inc == LINE) ? IDLE : (own_dc ? GNT_DC : GNT_IC);
        cnt_nx     = own_en ? cnt_inc : '0;
        last_dc_nx = (state == IDLE && own_en) ? own_dc : last_dc;
        bt_wr_nx   = (state == IDLE && own_en) ? own_wr : bt_wr;
    end

    // State registers; reset leaves last_dc set so the icache wins the first tie
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= IDLE;
            cnt     <= '0;
            last_dc <= 1'b1;
            bt_wr   <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            last_dc <= last_dc_nx;
            bt_wr   <= bt_wr_nx;
        end
    end

    assign act         = rstn && own_en;
    assign mem_rd_en   = act && !own_wr;
    assign mem_wr_en   = act && own_wr;
    assign mem_addr    = own_dc ? dc_addr : ic_rd_addr;
    assign mem_wr_data = dc_wr_data;
    assign mem_wr_sel  = dc_wr_sel;
    assign gnt         = (rstn && (busy || own_en)) ? {own_dc, !own_dc} : 2'b00;
    assign ic_rd_valid = rstn && beat && !own_dc;
    assign dc_rd_valid = rstn && beat && own_dc && !own_wr;
    assign dc_wr_ack   = rstn && beat && own_wr;
    assign ic_rd_data  = mem_rd_data;
    assign dc_rd_data  = mem_rd_data;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bursts for mem_arbiter with a beat scoreboard
module tb_mem_arbiter;
    localparam logic [2:0] IC = 3'b100, DCR = 3'b010, DCW = 3'b001, NONE = 3'b000;

    typedef struct {
        logic [2:0]  dst;
        logic [31:0] data;
    } sb_t;

    logic        clk, rstn;
    logic        ic_rd_en, ic_rd_valid, dc_rd_en, dc_wr_en, dc_rd_valid, dc_wr_ack;
    logic [15:0] ic_rd_addr, dc_addr, mem_addr;
    logic [31:0] ic_rd_data, dc_rd_data, dc_wr_data, mem_wr_data, mem_rd_data;
    logic [3:0]  dc_wr_sel, mem_wr_sel;
    logic        mem_rd_en, mem_wr_en, mem_rd_valid, mem_wr_ack;
    logic [1:0]  gnt;
    sb_t         sb[$];
    int          passed = 0;
    int          total = 0;

    mem_arbiter dut (
        .clk(clk), .rstn(rstn),
        .ic_rd_en(ic_rd_en), .ic_rd_addr(ic_rd_addr), .ic_rd_data(ic_rd_data), .ic_rd_valid(ic_rd_valid),
        .dc_rd_en(dc_rd_en), .dc_wr_en(dc_wr_en), .dc_addr(dc_addr), .dc_wr_data(dc_wr_data),
        .dc_wr_sel(dc_wr_sel), .dc_rd_data(dc_rd_data), .dc_rd_valid(dc_rd_valid), .dc_wr_ack(dc_wr_ack),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
        .mem_wr_sel(mem_wr_sel), .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid),
        .mem_wr_ack(mem_wr_ack), .gnt(gnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One clock cycle: drive memory response, check at negedge, leave 1 unit after the next posedge
    task automatic cyc(input string tag, input logic rv, input logic wa, input logic [1:0] eg,
                       input logic erd, input logic ewr, input logic [2:0] ed);
        sb_t         e;
        logic [2:0]  obs;
        logic [15:0] ea;
        mem_rd_valid = rv;
        mem_wr_ack   = wa;
        mem_rd_data  = $urandom;
        if (ed != NONE) sb.push_back('{ed, mem_rd_data});
        @(negedge clk);
        chk({tag, "_gnt"}, gnt, eg);
        chk({tag, "_en"}, {mem_rd_en, mem_wr_en}, {erd, ewr});
        obs = {ic_rd_valid, dc_rd_valid, dc_wr_ack};
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_dst"}, obs, e.dst);
            if (e.dst == IC) chk({tag, "_icdata"}, ic_rd_data, e.data);
            if (e.dst == DCR) chk({tag, "_dcdata"}, dc_rd_data, e.data);
        end else begin
            chk({tag, "_noval"}, obs, NONE);
        end
        if (eg != 2'b00) begin
            ea = eg[1] ? dc_addr : ic_rd_addr;
            chk({tag, "_addr"}, mem_addr, ea);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        ic_rd_en = 1'b1;
        dc_rd_en = 1'b1;
        dc_wr_en = 1'b1;
        cyc("rst_a", 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, NONE);
        cyc("rst_b", 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, NONE);
        rstn = 1'b1;
        ic_rd_en = 1'b0;
        dc_rd_en = 1'b0;
        dc_wr_en = 1'b0;
    endtask

    initial begin
        rstn = 1'b0;
        ic_rd_en = 1'b0;
        dc_rd_en = 1'b0;
        dc_wr_en = 1'b0;
        ic_rd_addr = '0;
        dc_addr = '0;
        dc_wr_data = '0;
        dc_wr_sel = '0;
        mem_rd_data = '0;
        mem_rd_valid = 1'b0;
        mem_wr_ack = 1'b0;
        @(posedge clk);
        #1;
        do_reset();
        // icache alone, back-to-back beats, then stray responses while idle
        ic_rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ic_rd_addr = 16'h0040 + 16'(i);
            cyc("t1_beat", 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, IC);
        end
        ic_rd_en = 1'b0;
        cyc("t1_rel", 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, NONE);
        cyc("t1_stray", 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, NONE);
        // simultaneous requests after reset: icache first, then dcache
        do_reset();
        ic_rd_en = 1'b1;
        dc_rd_en = 1'b1;
        ic_rd_addr = 16'h0100;
        dc_addr = 16'h2000;
        for (int i = 0; i < 4; i++) cyc("t2_ic", 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, IC);
        ic_rd_en = 1'b0;
        cyc("t2_gap", 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, NONE);
        for (int i = 0; i < 4; i++) cyc("t2_dc", 1'b1, 1'b0, 2'b10, 1'b1, 1'b0, DCR);
        dc_rd_en = 1'b0;
        cyc("t2_end", 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, NONE);
        // writeback before refill; stray read valids ignored during the write burst
        dc_wr_en = 1'b1;
        dc_rd_en = 1'b1;
        dc_addr = 16'h1230;
        dc_wr_data = 32'hCAFE0001;
        dc_wr_sel = 4'b1010;
        cyc("t3_wr", 1'b0, 1'b1, 2'b10, 1'b0, 1'b1, DCW);
        chk("t3_wdata", mem_wr_data, 32'hCAFE0001);
        chk("t3_wsel", mem_wr_sel, 4'b1010);
        for (int i = 0; i < 3; i++) cyc("t3_wr", 1'b1, 1'b1, 2'b10, 1'b0, 1'b1, DCW);
        dc_wr_en = 1'b0;
        cyc("t3_gap", 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, NONE);
        // refill with 3-cycle gaps between valids
        cyc("t4_gnt", 1'b0, 1'b0, 2'b10, 1'b1, 1'b0, NONE);
        for (int b = 0; b < 4; b++) begin
            for (int g = 0; g < 3; g++) cyc("t4_wait", 1'b0, 1'b1, 2'b10, 1'b1, 1'b0, NONE);
            cyc("t4_beat", 1'b1, 1'b0, 2'b10, 1'b1, 1'b0, DCR);
        end
        dc_rd_en = 1'b0;
        cyc("t4_end", 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, NONE);
        // dcache aborts after 2 beats; pending icache is granted next
        dc_rd_en = 1'b1;
        dc_addr = 16'h3000;
        cyc("t5_dc", 1'b1, 1'b0, 2'b10, 1'b1, 1'b0, DCR);
        ic_rd_en = 1'b1;
        ic_rd_addr = 16'h0200;
        cyc("t5_dc", 1'b1, 1'b0, 2'b10, 1'b1, 1'b0, DCR);
        dc_rd_en = 1'b0;
        cyc("t5_abort", 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, NONE);
        for (int i = 0; i < 4; i++) cyc("t5_ic", 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, IC);
        ic_rd_en = 1'b0;
        cyc("t5_end", 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, NONE);
        // reset during beat 2 of an icache burst, then a fresh burst from the base address
        ic_rd_en = 1'b1;
        ic_rd_addr = 16'h0080;
        cyc("t6_b1", 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, IC);
        rstn = 1'b0;
        cyc("t6_rst", 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, NONE);
        rstn = 1'b1;
        cyc("t6_restart", 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, IC);
        chk("t6_base", mem_addr, 16'h0080);
        for (int i = 0; i < 3; i++) cyc("t6_ic", 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, IC);
        ic_rd_en = 1'b0;
        cyc("t6_end", 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, NONE);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
